// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      LOAD  = 2'd2,
      SHIFT = 2'd3
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_unit_bit_counter.sv
// Up-counter with synchronous clear/enable; tc flags the last bit position.
module bit_counter #(
   parameter int CNT_W = 3,
   parameter int LAST  = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CNT_W-1:0] LAST_V = CNT_W'(LAST);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == LAST_V);

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial two's-complement add/subtract, LSB first, with press/release launch FSM.
module serial_addsub_unit
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             done,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             sum_bit;
   logic             carry_nxt;
   logic             cnt_clr;
   logic             cnt_en;
   logic             cnt_tc;

   assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

   assign cnt_clr = (state_q == IDLE);
   assign cnt_en  = (state_q == SHIFT);

   bit_counter #(
      .CNT_W (CNT_W),
      .LAST  (WIDTH - 1)
   ) u_bit_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .tc  (cnt_tc)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      result_d = result_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = ARMED;
         end
         ARMED: begin
            if (!start) state_d = LOAD;
         end
         // Subtraction is A + ~B + 1, so the mode lives on in the inverted B and the seed carry.
         LOAD: begin
            a_sh_d   = a_in;
            b_sh_d   = (mode == MODE_SUB) ? ~b_in : b_in;
            carry_d  = (mode == MODE_SUB);
            result_d = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
            state_d  = SHIFT;
         end
         SHIFT: begin
            result_d = {sum_bit, result_q[WIDTH-1:1]};
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            carry_d  = carry_nxt;
            if (cnt_tc) begin
               cout_d  = carry_nxt;
               ovf_d   = carry_q ^ carry_nxt;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;
   assign done   = (state_q == IDLE);
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit at WIDTH=8 and WIDTH=16 with a queued expected-result scoreboard.
module tb_serial_addsub_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       start8 = 1'b0, mode8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, result8;
   logic       cout8, ovf8, done8, busy8;

   logic        start16 = 1'b0, mode16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0, result16;
   logic        cout16, ovf16, done16, busy16;

   int checks   = 0;
   int failures = 0;

   // Entries are {result, cout, ovf}.
   logic [9:0]  exp_q8[$];
   logic [17:0] exp_q16[$];

   always #5 clk = ~clk;

   serial_addsub_unit #(.WIDTH(8)) dut8 (
      .clk (clk), .rst (rst), .start (start8), .mode (mode8),
      .a_in (a8), .b_in (b8), .result (result8), .cout (cout8),
      .ovf (ovf8), .done (done8), .busy (busy8)
   );

   serial_addsub_unit #(.WIDTH(16)) dut16 (
      .clk (clk), .rst (rst), .start (start16), .mode (mode16),
      .a_in (a16), .b_in (b16), .result (result16), .cout (cout16),
      .ovf (ovf16), .done (done16), .busy (busy16)
   );

   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic m);
      logic [7:0] be;
      logic [8:0] s;
      logic       o;
      be = m ? ~b : b;
      s  = {1'b0, a} + {1'b0, be} + {8'd0, m};
      o  = (a[7] == be[7]) && (s[7] != a[7]);
      return {s[7:0], s[8], o};
   endfunction

   function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic m);
      logic [15:0] be;
      logic [16:0] s;
      logic        o;
      be = m ? ~b : b;
      s  = {1'b0, a} + {1'b0, be} + {16'd0, m};
      o  = (a[15] == be[15]) && (s[15] != a[15]);
      return {s[15:0], s[16], o};
   endfunction

   // Press and release; returns just after the release edge (E0).
   task automatic press8(input logic [7:0] a, input logic [7:0] b, input logic m);
      exp_q8.push_back(model8(a, b, m));
      a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic press16(input logic [15:0] a, input logic [15:0] b, input logic m);
      exp_q16.push_back(model16(a, b, m));
      a16 = a; b16 = b; mode16 = m; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      @(posedge clk); #1;
   endtask

   // Counts edges after E0 until done; optionally scrambles inputs during SHIFT or pulses start.
   task automatic wait_done8(input bit toggle, input int pulse_at, output int lat);
      lat = 0;
      while (!done8 && lat < 40) begin
         if (toggle && lat >= 1) begin
            a8    = 8'($urandom_range(0, 255));
            b8    = 8'($urandom_range(0, 255));
            mode8 = ~mode8;
         end
         start8 = (lat == pulse_at);
         @(posedge clk); #1;
         lat++;
      end
      start8 = 1'b0;
   endtask

   task automatic wait_done16(output int lat);
      lat = 0;
      while (!done16 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({result8, cout8, ovf8, done8, busy8} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset8 got res=%h cout=%b ovf=%b done=%b busy=%b want 00 0 0 1 0",
                  result8, cout8, ovf8, done8, busy8);
      end
      checks++;
      if ({result16, cout16, ovf16, done16, busy16} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset16 got res=%h cout=%b ovf=%b done=%b busy=%b want 0000 0 0 1 0",
                  result16, cout16, ovf16, done16, busy16);
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add_basic;
      int          lat;
      logic [9:0]  exp;
      press8(8'h5A, 8'h33, 1'b0);
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b1) begin
         failures++;
         $display("FAIL load_busy got done=%b busy=%b want 0 1", done8, busy8);
      end
      wait_done8(1'b0, -1, lat);
      exp = exp_q8.pop_front();
      checks++;
      if ({result8, cout8, ovf8} !== exp) begin
         failures++;
         $display("FAIL add_5a_33 got %h/%b/%b want %h/%b/%b", result8, cout8, ovf8, exp[9:2], exp[1], exp[0]);
      end
      checks++;
      if (lat != 9) begin
         failures++;
         $display("FAIL latency8 got %0d want 9", lat);
      end
   endtask

   task automatic test_carry_and_sub;
      int          lat;
      logic [9:0]  exp;
      press8(8'hFF, 8'h01, 1'b0);
      wait_done8(1'b0, -1, lat);
      exp = exp_q8.pop_front();
      checks++;
      if ({result8, cout8, ovf8} !== exp || lat != 9) begin
         failures++;
         $display("FAIL add_ff_01 got %h/%b/%b lat=%0d want %h/%b/%b lat=9",
                  result8, cout8, ovf8, lat, exp[9:2], exp[1], exp[0]);
      end
      press8(8'h80, 8'h01, 1'b1);
      wait_done8(1'b0, -1, lat);
      exp = exp_q8.pop_front();
      checks++;
      if ({result8, cout8, ovf8} !== exp || lat != 9) begin
         failures++;
         $display("FAIL sub_80_01 got %h/%b/%b lat=%0d want %h/%b/%b lat=9",
                  result8, cout8, ovf8, lat, exp[9:2], exp[1], exp[0]);
      end
   endtask

   task automatic test_input_isolation;
      int          lat;
      logic [9:0]  exp;
      press8(8'h10, 8'h20, 1'b1);
      wait_done8(1'b1, -1, lat);
      exp = exp_q8.pop_front();
      checks++;
      if ({result8, cout8, ovf8} !== exp || lat != 9) begin
         failures++;
         $display("FAIL sub_toggle got %h/%b/%b lat=%0d want %h/%b/%b lat=9",
                  result8, cout8, ovf8, lat, exp[9:2], exp[1], exp[0]);
      end
   endtask

   task automatic test_hold_and_pulse;
      int          lat;
      logic [7:0]  prev;
      logic [9:0]  exp;
      prev = result8;
      exp_q8.push_back(model8(8'h3C, 8'h45, 1'b0));
      a8 = 8'h3C; b8 = 8'h45; mode8 = 1'b0; start8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (busy8 !== 1'b1 || result8 !== prev) begin
            failures++;
            $display("FAIL hold_armed cyc=%0d got busy=%b res=%h want 1 %h", i, busy8, result8, prev);
         end
      end
      start8 = 1'b0;
      @(posedge clk); #1;
      wait_done8(1'b0, 4, lat);
      exp = exp_q8.pop_front();
      checks++;
      if ({result8, cout8, ovf8} !== exp || lat != 9) begin
         failures++;
         $display("FAIL pulse_shift got %h/%b/%b lat=%0d want %h/%b/%b lat=9",
                  result8, cout8, ovf8, lat, exp[9:2], exp[1], exp[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (done8 !== 1'b1) begin
         failures++;
         $display("FAIL stay_idle got done=%b want 1", done8);
      end
   endtask

   task automatic test_reset_mid_shift;
      int          lat;
      logic [9:0]  exp;
      press8(8'hC3, 8'h5E, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      void'(exp_q8.pop_back());
      checks++;
      if ({result8, cout8, ovf8, done8, busy8} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL mid_reset got res=%h cout=%b ovf=%b done=%b busy=%b want 00 0 0 1 0",
                  result8, cout8, ovf8, done8, busy8);
      end
      press8(8'h01, 8'h01, 1'b0);
      wait_done8(1'b0, -1, lat);
      exp = exp_q8.pop_front();
      checks++;
      if ({result8, cout8, ovf8} !== exp || result8 !== 8'h02 || lat != 9) begin
         failures++;
         $display("FAIL after_reset got %h/%b/%b lat=%0d want %h/%b/%b lat=9",
                  result8, cout8, ovf8, lat, exp[9:2], exp[1], exp[0]);
      end
   endtask

   task automatic test_back_to_back;
      int          lat;
      logic [7:0]  a, b;
      logic        m;
      logic [9:0]  exp;
      for (int n = 0; n < 6; n++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         m = 1'($urandom_range(0, 1));
         press8(a, b, m);
         wait_done8(1'b0, -1, lat);
         exp = exp_q8.pop_front();
         checks++;
         if ({result8, cout8, ovf8} !== exp || lat != 9) begin
            failures++;
            $display("FAIL b2b_%0d a=%h b=%h m=%b got %h/%b/%b lat=%0d want %h/%b/%b",
                     n, a, b, m, result8, cout8, ovf8, lat, exp[9:2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic test_wide;
      int           lat;
      logic [17:0]  exp;
      press16(16'h7FFF, 16'h0001, 1'b0);
      wait_done16(lat);
      exp = exp_q16.pop_front();
      checks++;
      if ({result16, cout16, ovf16} !== exp) begin
         failures++;
         $display("FAIL add16 got %h/%b/%b want %h/%b/%b", result16, cout16, ovf16, exp[17:2], exp[1], exp[0]);
      end
      checks++;
      if (lat != 17) begin
         failures++;
         $display("FAIL latency16 got %0d want 17", lat);
      end
      press16(16'h1234, 16'h4321, 1'b1);
      wait_done16(lat);
      exp = exp_q16.pop_front();
      checks++;
      if ({result16, cout16, ovf16} !== exp || lat != 17) begin
         failures++;
         $display("FAIL sub16 got %h/%b/%b lat=%0d want %h/%b/%b lat=17",
                  result16, cout16, ovf16, lat, exp[17:2], exp[1], exp[0]);
      end
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_carry_and_sub();
      test_input_isolation();
      test_hold_and_pulse();
      test_reset_mid_shift();
      test_back_to_back();
      test_wide();
      checks++;
      if (exp_q8.size() != 0 || exp_q16.size() != 0) begin
         failures++;
         $display("FAIL queue_drain got %0d/%0d want 0/0", exp_q8.size(), exp_q16.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_addsub_unit.md
# serial_addsub_unit

Parametrised bit-serial two's-complement adder/subtractor with its own control FSM, operand shift registers, carry flip-flop and cycle counter. It is the next generation of the quad serial adder controller: the operand width is generic, it supports an add/subtract mode, it reports carry and signed overflow, and it provides a busy flag. It sits between the input-capture logic, which supplies operands and the start button, and the result display/register stage.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), derived localparam (not overridable); counter width.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- start  in  1  level; press-and-release launches one operation.
- mode  in  1  0 = A+B, 1 = A−B; sampled in LOAD only.
- a_in  in  WIDTH  operand A; sampled in LOAD only.
- b_in  in  WIDTH  operand B; sampled in LOAD only.
- result  out  WIDTH  registered sum/difference; holds until next LOAD.
- cout  out  1  registered final carry (sub: 1 = no borrow).
- ovf  out  1  registered signed overflow.
- done  out  1  high in IDLE.
- busy  out  1  high in ARMED, LOAD, SHIFT (equal to ~done).

## Operation
- FSM states: IDLE, ARMED, LOAD, SHIFT.
  - IDLE: done=1; counter cleared; start=1 → ARMED; otherwise stay.
  - ARMED: wait for release; start=1 → stay; start=0 → LOAD.
  - LOAD (exactly 1 cycle): A_sh←a_in; B_sh←(mode ? ~b_in : b_in); carry←mode; result←0; cout, ovf←0; mode latched; → SHIFT.
  - SHIFT: per cycle, s = A_sh[0]^B_sh[0]^carry, c' = maj(A_sh[0],B_sh[0],carry); result←{s, result[WIDTH-1:1]}; A_sh, B_sh shift right with 0 fill; carry←c'; counter increments. When count == WIDTH-1: cout←c', ovf←carry^c' (carry into MSB xor carry out), → IDLE.
- Arithmetic is modulo 2^WIDTH, LSB first; result is exactly WIDTH bits.
- start is ignored in LOAD and SHIFT. An operation cannot be restarted or aborted except by rst.
- Changes to a_in, b_in or mode after LOAD have no effect.
- In IDLE, result, cout and ovf hold the last completed operation.

## Timing
- Reset (rst=0 at an edge): state→IDLE, counter→0, result→0, cout→0, ovf→0, shift registers and carry→0. After reset: done=1, busy=0. Reset takes priority over every state, including mid-SHIFT; the partial result is discarded.
- Latency: the edge that samples start=0 in ARMED is E0. LOAD occupies E0–E1, SHIFT occupies E1–E(WIDTH+1). done rises and result/cout/ovf are valid right after E(WIDTH+1), which is WIDTH+1 edges after E0.
- Throughput: the minimum gap from one done to the next is 1 IDLE cycle + 1 ARMED cycle + (WIDTH+1) cycles.
- If start is already high when the FSM re-enters IDLE, the next edge goes to ARMED, and a release is still required to launch.
- done and busy are decoded from state (Moore) and are glitch-free relative to clk.

## Structure
- Package serial_addsub_pkg: state enum (IDLE, ARMED, LOAD, SHIFT, 2-bit), MODE_ADD/MODE_SUB constants.
- Sub-module bit_counter: parametrised CNT_W up-counter with synchronous clear, enable and terminal-count output (tc when count == WIDTH-1). The FSM clears it in IDLE and enables it in SHIFT.
- Datapath (shift registers, full adder, carry flop) lives in the top module. There is no separate datapath module.

## Test plan
- WIDTH=8, mode=0, A=0x5A, B=0x33, press/release → result=0x8D, cout=0, ovf=1; done rises exactly 9 edges after the release edge.
- WIDTH=8, mode=0, A=0xFF, B=0x01 → result=0x00, cout=1, ovf=0. Then mode=1, A=0x80, B=0x01 → result=0x7F, cout=1, ovf=1.
- WIDTH=8, mode=1, A=0x10, B=0x20 → result=0xF0, cout=0, ovf=0. Toggle a_in, b_in and mode every cycle during SHIFT → result still 0xF0.
- Hold start high for 5 cycles → state remains ARMED, busy=1, result unchanged. Pulse start again mid-SHIFT → no restart, done timing unchanged.
- Drive rst=0 for one edge at the 4th SHIFT cycle → next cycle: result=0, cout=0, ovf=0, done=1, busy=0. A subsequent operation 0x01+0x01 → result=0x02.
- WIDTH=16, mode=0, A=0x7FFF, B=0x0001 → result=0x8000, ovf=1, cout=0; done rises 17 edges after the release edge.
